// File: rtl/mdio_master_if.sv
// mdio_master_if: clause-22 MDIO initiator, one complete 64-bit MDC/MDIO frame per command.
// Optional build macro MDIO_MASTER_TA_CHECK_EN: flag reads whose turnaround sample was not driven low.
module mdio_master_if #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mdc_o,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);
    // state    | meaning
    // ST_IDLE  | bus released, MDC parked low, ready for a command
    // ST_FRAME | shifting the 64 frame bits, MDC toggling
    // ST_DONE  | one-cycle response pulse, then back to idle
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  bit_q;
    logic [63:0] sh_q;
    logic        write_q;
    logic [15:0] rd_sh_q;
    logic [15:0] rdata_q;
    logic        mdc_q;
    logic        oe_q;
    logic        ready_q;
    logic        valid_q;
    logic        busy_q;
    logic [63:0] frame_d;
`ifdef MDIO_MASTER_TA_CHECK_EN
    logic        ta_q;
    logic        err_q;
`endif

    // Read frames leave TA and data as ones; those bits are never driven.
    always_comb begin
        frame_d = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy, cmd_reg,
                   (cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '1;
            write_q <= 1'b0;
            rd_sh_q <= '0;
            rdata_q <= '0;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MDIO_MASTER_TA_CHECK_EN
            ta_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mdc_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        state_q <= ST_FRAME;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        oe_q    <= 1'b1;
                        sh_q    <= frame_d;
                        write_q <= cmd_write;
                        div_q   <= DIV_TC;
                        bit_q   <= '0;
                    end
                end
                ST_FRAME: begin
                    // First clk cycle of the MDC high half: sample TA and read data.
                    if (mdc_q && div_q == DIV_TC && bit_q >= 6'd47) begin
                        rd_sh_q <= {rd_sh_q[14:0], mdio_i};
`ifdef MDIO_MASTER_TA_CHECK_EN
                        if (bit_q == 6'd47) ta_q <= mdio_i;
`endif
                    end
                    if (div_q != 8'd0) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q <= DIV_TC;
                        if (!mdc_q) begin
                            mdc_q <= 1'b1;
                        end else begin
                            mdc_q <= 1'b0;
                            if (bit_q == 6'd63) begin
                                state_q <= ST_DONE;
                                oe_q    <= 1'b0;
                                valid_q <= 1'b1;
                                sh_q    <= '1;
                                if (!write_q) rdata_q <= rd_sh_q;
`ifdef MDIO_MASTER_TA_CHECK_EN
                                err_q   <= !write_q && ta_q;
`endif
                            end else begin
                                bit_q <= bit_q + 6'd1;
                                sh_q  <= {sh_q[62:0], 1'b1};
                                oe_q  <= write_q || (bit_q < 6'd45);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mdc_o     = mdc_q;
    assign mdio_o    = sh_q[63];
    assign mdio_oe   = oe_q;
    assign cmd_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
`ifdef MDIO_MASTER_TA_CHECK_EN
    assign rsp_error = err_q;
`else
    assign rsp_error = 1'b0;
`endif
endmodule
